// File: rtl/mtf_token_encoder.sv
// ============================================================================
//  Module   : mtf_token_encoder
//  Purpose  : Encodes symbols as MTF hit/miss tokens and buffers them in a FWFT FIFO
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mtf_token_encoder #(
  parameter int WIDTH = 8,
  parameter int NUM   = 4,
  parameter int IDXW  = $clog2(NUM),
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         data_valid_in,
  input  logic [NUM*WIDTH-1:0]         list_in,
  input  logic [NUM-1:0]               list_valid_in,
  output logic [WIDTH:0]               out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         overflow,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [CNTW-1:0]              hit_count,
  output logic [CNTW-1:0]              miss_count
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int LVLW = $clog2(DEPTH+1);
  localparam logic [LVLW-1:0] c_full = LVLW'(DEPTH);

  logic [NUM-1:0]  w_match;
  logic            w_hit;
  logic [IDXW-1:0] w_idx;
  logic [WIDTH:0]  w_token;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  logic [WIDTH:0]  r_mem [DEPTH];
  logic [PTRW-1:0] r_wptr;
  logic [PTRW-1:0] r_rptr;
  logic [LVLW-1:0] r_level;
  logic            r_overflow;
  logic [CNTW-1:0] r_hit_count;
  logic [CNTW-1:0] r_miss_count;

  // Scan from the oldest entry down so the most recent match is left standing.
  always_comb begin
    w_match = '0;
    w_hit   = 1'b0;
    w_idx   = '0;
    for (int i = NUM-1; i >= 0; i--) begin
      w_match[i] = list_valid_in[i] && (list_in[i*WIDTH +: WIDTH] == data_in);
      if (w_match[i]) begin
        w_hit = 1'b1;
        w_idx = IDXW'(i);
      end
    end
  end

  assign w_token = w_hit ? {1'b1, WIDTH'(w_idx)} : {1'b0, data_in};

  assign w_pop  = (r_level != '0) && out_ready;
  assign w_push = data_valid_in && ((r_level != c_full) || w_pop);
  assign w_drop = data_valid_in && (r_level == c_full) && !w_pop;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_overflow   <= 1'b0;
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      // Statistics see every valid symbol, dropped or not.
      if (data_valid_in) begin
        if (w_hit) begin
          if (r_hit_count != '1) r_hit_count <= r_hit_count + 1'b1;
        end else begin
          if (r_miss_count != '1) r_miss_count <= r_miss_count + 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk_in) begin
    if (!rst_in && w_push) begin
      r_mem[r_wptr] <= w_token;
    end
  end

  assign out_valid  = (r_level != '0);
  assign out        = out_valid ? r_mem[r_rptr] : '0;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

`default_nettype wire

// File: tb/tb_mtf_token_encoder.sv
// ============================================================================
//  Module   : tb_mtf_token_encoder
//  Purpose  : Directed self-checking bench for mtf_token_encoder
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mtf_token_encoder;

  localparam int WIDTH = 8;
  localparam int NUM   = 4;
  localparam int DEPTH = 4;
  localparam int CNTW  = 16;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic [WIDTH-1:0]     data_in;
  logic                 data_valid_in;
  logic [NUM*WIDTH-1:0] list_in;
  logic [NUM-1:0]       list_valid_in;
  logic [WIDTH:0]       out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 overflow;
  logic [2:0]           level;
  logic [CNTW-1:0]      hit_count;
  logic [CNTW-1:0]      miss_count;

  int vectors = 0;
  int errors  = 0;

  mtf_token_encoder #(.WIDTH(WIDTH), .NUM(NUM), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .data_valid_in(data_valid_in),
    .list_in(list_in), .list_valid_in(list_valid_in), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .overflow(overflow), .level(level),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [WIDTH:0] exp_out, input logic exp_valid,
                          input logic [2:0] exp_level);
    vectors++;
    if (out !== exp_out || out_valid !== exp_valid || level !== exp_level) begin
      errors++;
      $display("FAIL %s: out=%h valid=%b level=%0d, want out=%h valid=%b level=%0d",
               name, out, out_valid, level, exp_out, exp_valid, exp_level);
    end
  endtask

  task automatic chk_stats(input string name, input logic [CNTW-1:0] exp_hit,
                           input logic [CNTW-1:0] exp_miss, input logic exp_ovf);
    vectors++;
    if (hit_count !== exp_hit || miss_count !== exp_miss || overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s: hit=%0d miss=%0d ovf=%b, want hit=%0d miss=%0d ovf=%b",
               name, hit_count, miss_count, overflow, exp_hit, exp_miss, exp_ovf);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; data_valid_in = 1'b0; data_in = '0; list_in = '0;
    list_valid_in = '0; out_ready = 1'b1;
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk_head("reset_idle", 9'h000, 1'b0, 3'd0);
    chk_stats("reset_stats", 16'd0, 16'd0, 1'b0);
  endtask

  task automatic test_miss();
    list_valid_in = 4'b0000; data_in = 8'h05; data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    chk_head("miss_token", 9'h005, 1'b1, 3'd1);
    chk_stats("miss_stats", 16'd0, 16'd1, 1'b0);
    tick();
    chk_head("miss_drained", 9'h000, 1'b0, 3'd0);
  endtask

  task automatic test_hit();
    list_in = {8'h04, 8'h01, 8'h02, 8'h03};
    list_valid_in = 4'b1111; data_in = 8'h01; data_valid_in = 1'b1;
    tick();
    chk_head("hit_token", 9'h102, 1'b1, 3'd1);
    chk_stats("hit_stats", 16'd1, 16'd1, 1'b0);
    // Head 9'h102 is popped on the same edge the masked lookup is pushed.
    list_valid_in = 4'b0011;
    tick();
    data_valid_in = 1'b0;
    chk_head("hit_masked_miss", 9'h001, 1'b1, 3'd1);
    chk_stats("hit_masked_stats", 16'd1, 16'd2, 1'b0);
    tick();
  endtask

  task automatic test_duplicate();
    list_in = {8'h07, 8'h09, 8'h07, 8'h08};
    list_valid_in = 4'b1111; data_in = 8'h07; data_valid_in = 1'b1;
    tick();
    data_valid_in = 1'b0;
    chk_head("dup_priority", 9'h101, 1'b1, 3'd1);
    chk_stats("dup_stats", 16'd2, 16'd2, 1'b0);
    tick();
    chk_head("dup_drained", 9'h000, 1'b0, 3'd0);
  endtask

  task automatic test_backpressure();
    logic [WIDTH:0] exp_seq [4] = '{9'h010, 9'h011, 9'h012, 9'h013};
    out_ready = 1'b0; list_valid_in = 4'b0000; data_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h10 + 8'(i);
      tick();
    end
    chk_head("bp_full", 9'h010, 1'b1, 3'd4);
    chk_stats("bp_no_ovf_yet", 16'd2, 16'd6, 1'b0);
    data_in = 8'h14;
    tick();
    data_valid_in = 1'b0;
    chk_head("bp_drop_untouched", 9'h010, 1'b1, 3'd4);
    chk_stats("bp_overflow", 16'd2, 16'd7, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("bp_pop%0d", i), exp_seq[i], 1'b1, 3'(4 - i));
      tick();
    end
    chk_head("bp_empty", 9'h000, 1'b0, 3'd0);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH:0] exp_seq [4] = '{9'h01b, 9'h01c, 9'h01d, 9'h020};
    out_ready = 1'b0; list_valid_in = 4'b0000; data_valid_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h1a + 8'(i);
      tick();
    end
    chk_head("b2b_full", 9'h01a, 1'b1, 3'd4);
    out_ready = 1'b1; data_in = 8'h20;
    tick();
    data_valid_in = 1'b0;
    chk_stats("b2b_no_drop_stats", 16'd2, 16'd12, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk_head($sformatf("b2b_order%0d", i), exp_seq[i], 1'b1, 3'(4 - i));
      if (i < 3) tick();
    end
    // Leave two tokens buffered, then reset while a push and pop are requested.
    out_ready = 1'b0; data_in = 8'h30; data_valid_in = 1'b1;
    tick();
    chk_head("b2b_prereset", 9'h020, 1'b1, 3'd2);
    rst_in = 1'b1; out_ready = 1'b1; data_in = 8'h31;
    tick();
    rst_in = 1'b0; data_valid_in = 1'b0;
    chk_head("mid_reset_head", 9'h000, 1'b0, 3'd0);
    chk_stats("mid_reset_stats", 16'd0, 16'd0, 1'b0);
    tick();
    chk_head("post_reset_idle", 9'h000, 1'b0, 3'd0);
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_miss();
        test_hit();
        test_duplicate();
        test_backpressure();
        test_back_to_back();
      end
      begin
        #100000;
        $display("FAIL timeout: run did not complete within time limit");
        $fatal(1, "timeout");
      end
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mtf_token_encoder.md
Name: mtf_token_encoder

Overview:
- Downstream consumer of the move-to-front recency list stage.
- Each cycle it takes the current input symbol together with that stage's list snapshot from the same cycle, before the list updates. It encodes the symbol as either a hit token carrying the list index or a miss token carrying the literal.
- Tokens are buffered in a small first-word-fall-through (FWFT) FIFO with valid/ready output.
- The upstream stage cannot stall. Tokens that arrive when the FIFO is full are dropped and flagged.

Parameters:
- WIDTH, 8, symbol width; must match the list stage.
- NUM, 4, list entries; must match the list stage; power of two, at least 2.
- IDXW, $clog2(NUM), hit index width; derived, not overridden; must be at most WIDTH.
- DEPTH, 4, token FIFO depth; power of two, at least 2.
- CNTW, 16, statistics counter width.

Ports:
- clk_in, input, 1, clock; all logic on rising edge.
- rst_in, input, 1, synchronous active-high reset.
- data_in, input, WIDTH, symbol presented to the list stage this cycle.
- data_valid_in, input, 1, data_in carries a symbol to encode.
- list_in, input, NUM*WIDTH, list contents; entry i at bits [i*WIDTH +: WIDTH]; entry 0 is most recent.
- list_valid_in, input, NUM, per-entry valid mask from the list stage.
- out, output, WIDTH+1, token at FIFO head; bit WIDTH is the hit flag; low WIDTH bits carry index or literal.
- out_valid, output, 1, token at head is valid.
- out_ready, input, 1, consumer accepts the head token.
- overflow, output, 1, sticky: at least one token was dropped.
- level, output, $clog2(DEPTH+1), current FIFO occupancy.
- hit_count, output, CNTW, valid symbols found in the list.
- miss_count, output, CNTW, valid symbols not found in the list.

Behaviour:
- Match (combinational): match[i] = list_valid_in[i] AND (list_in entry i == data_in).
  - Hit = any match[i] set.
  - Index = lowest i with match[i] set; the most recent entry wins if the list contains duplicates.
- Token format:
  - Hit: {1'b1, index zero-extended to WIDTH}.
  - Miss: {1'b0, data_in}.
- Push: a token is pushed when data_valid_in=1 and the FIFO accepts it. No token is generated when data_valid_in=0.
- Pop: occurs when out_valid=1 and out_ready=1.
- FIFO accepts a push when level<DEPTH, or when level==DEPTH and a pop occurs in the same cycle.
- Simultaneous push and pop: level is unchanged and ordering is preserved.
- Full FIFO, no pop, data_valid_in=1:
  - Token is dropped.
  - overflow is set and held until reset.
  - FIFO contents are untouched.
- Read side is FWFT: out_valid = (level != 0) and out is the head entry. Pop with the FIFO empty is impossible because out_valid=0.
- Latency: a token pushed at edge N appears on out/out_valid after edge N when the FIFO was empty.
- out is stable while out_valid=1 and out_ready=0.
- Read and write pointers are log2(DEPTH) bits and wrap naturally. level is tracked explicitly, so full and empty are distinguishable.
- hit_count / miss_count:
  - Increment on every data_valid_in=1 cycle according to the hit result, including dropped tokens.
  - Saturate at all-ones.
- Reset (rst_in=1 at an edge):
  - Pointers cleared, level=0, out_valid=0.
  - overflow=0, hit_count=0, miss_count=0.
  - out=0 after reset.
  - Inputs are ignored during the reset cycle, including any push or pop.
- Reset mid-stream discards all buffered tokens. There is no partial drain.
- All outputs are registered or derived from registered state only. No input-to-output combinational path.

Test Plan (WIDTH=8, NUM=4, DEPTH=4, out_ready=1 unless stated):
- Reset then idle with data_valid_in=0 for 5 cycles -> out_valid=0, level=0, all counters 0, overflow=0.
- Miss:
  - Stimulus: list_valid_in=4'b0000, data_in=8'h05 valid for one cycle.
  - Response: next cycle out=9'h005, out_valid=1; miss_count=1.
- Hit:
  - Stimulus: list {0:8'h03, 1:8'h02, 2:8'h01, 3:8'h04}, valid 4'b1111, data_in=8'h01.
  - Response: out=9'h102, hit_count=1.
  - Repeat with list_valid_in=4'b0011 -> out=9'h001 (miss).
- Duplicate priority:
  - Stimulus: entries 1 and 3 both 8'h07, all valid, data_in=8'h07.
  - Response: out=9'h101.
- Backpressure and overflow:
  - Stimulus: out_ready=0; 5 consecutive valid misses 8'h10..8'h14.
  - Response: level=4; overflow=1 after the fifth; miss_count=5.
  - Then raise out_ready -> out pops 9'h010, 9'h011, 9'h012, 9'h013 in order, then out_valid=0.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full, out_ready=1, new valid miss 8'h20.
  - Response: no drop, level stays 4, 9'h020 emerges fourth.
  - Follow-on: assert rst_in mid-stream -> next cycle level=0, out_valid=0, overflow=0, counters 0.
